// File: rtl/buzzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pkg
// Description : Shared FSM state encoding, pitch codes and tone-period lookup
//               for the buzzer melody sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package buzzer_pkg;

    // Sequencer states; width is fixed so the register size never drifts.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Pitch codes held in the upper nibble of a note entry.
    localparam logic [3:0] c_PITCH_REST = 4'd0;
    localparam logic [3:0] c_PITCH_DO   = 4'd1;
    localparam logic [3:0] c_PITCH_RE   = 4'd2;
    localparam logic [3:0] c_PITCH_MI   = 4'd3;
    localparam logic [3:0] c_PITCH_FA   = 4'd4;
    localparam logic [3:0] c_PITCH_SO   = 4'd5;
    localparam logic [3:0] c_PITCH_LA   = 4'd6;
    localparam logic [3:0] c_PITCH_XI   = 4'd7;

    // Half-wave periods in system clocks.
    localparam logic [17:0] c_PERIOD_DO = 18'd190839;
    localparam logic [17:0] c_PERIOD_RE = 18'd170067;
    localparam logic [17:0] c_PERIOD_MI = 18'd151514;
    localparam logic [17:0] c_PERIOD_FA = 18'd143265;
    localparam logic [17:0] c_PERIOD_SO = 18'd127550;
    localparam logic [17:0] c_PERIOD_LA = 18'd113635;
    localparam logic [17:0] c_PERIOD_XI = 18'd101213;

    // Codes 8..15 have bit 3 set and are played as rests.
    function automatic logic pitch_audible(input logic [3:0] pitch);
        return (pitch != c_PITCH_REST) && !pitch[3];
    endfunction

    function automatic logic [17:0] pitch_period(input logic [3:0] pitch);
        logic [17:0] v_period;
        case (pitch)
            c_PITCH_DO: v_period = c_PERIOD_DO;
            c_PITCH_RE: v_period = c_PERIOD_RE;
            c_PITCH_MI: v_period = c_PERIOD_MI;
            c_PITCH_FA: v_period = c_PERIOD_FA;
            c_PITCH_SO: v_period = c_PERIOD_SO;
            c_PITCH_LA: v_period = c_PERIOD_LA;
            c_PITCH_XI: v_period = c_PERIOD_XI;
            default:    v_period = '0;
        endcase
        return v_period;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buzzer_melody_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_melody_seq_if
// Description : Control and tone-output bundle of the melody sequencer.
//               master = controller/tone generator side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface buzzer_melody_seq_if;

    logic        start;
    logic        stop;
    logic        loop_en;
    logic [17:0] period;
    logic        tone_en;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    modport master (
        output start, stop, loop_en,
        input  period, tone_en, busy, done, note_idx
    );

    modport slave (
        input  start, stop, loop_en,
        output period, tone_en, busy, done, note_idx
    );

endinterface
`default_nettype wire

// File: rtl/buzzer_note_rom.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_note_rom
// Description : 16 x 8 note table, entry n at TABLE[8n+7:8n]. Registered read,
//               data valid one cycle after the address is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_note_rom #(
    parameter logic [127:0] TABLE = '0
) (
    input  wire logic       clk,
    input  wire logic [3:0] i_addr,
    output logic      [7:0] o_data
);

    logic [7:0] r_data;

    // Synchronous table read.
    always_ff @(posedge clk) begin
        r_data <= TABLE[{i_addr, 3'b000} +: 8];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/buzzer_melody_seq.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_melody_seq
// Description : Plays a note table on a buzzer: each entry gives a pitch and a
//               duration in ticks, followed by a fixed silent gap. Supports
//               start/stop requests and looping at song end.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_melody_seq
    import buzzer_pkg::*;
#(
    parameter int unsigned  TICK_MAX   = 499_999,
    parameter int unsigned  SONG_LEN   = 16,
    parameter int unsigned  GAP_TICKS  = 2,
    parameter logic [127:0] NOTE_TABLE =
        128'h04_14_22_32_42_52_62_72_04_72_62_52_42_32_22_12
) (
    input  wire logic          system_clock,
    input  wire logic          system_reset,
    buzzer_melody_seq_if.slave bus
);

    localparam int unsigned          c_TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [c_TICK_W-1:0]  c_TICK_MAX = c_TICK_W'(TICK_MAX);
    localparam logic [3:0]           c_LAST_IDX = 4'(SONG_LEN - 1);
    localparam logic [3:0]           c_GAP      = 4'(GAP_TICKS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick_strobe;
    logic                w_tick_restart;
    logic [3:0]          r_dur_cnt;
    logic [3:0]          w_dur_cnt_nxt;
    logic [3:0]          r_gap_cnt;
    logic [3:0]          w_gap_cnt_nxt;
    logic [3:0]          r_note_idx;
    logic [3:0]          w_note_idx_nxt;
    logic [17:0]         r_period;
    logic [17:0]         w_period_nxt;
    logic                r_tone_en;
    logic                w_tone_en_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_end_of_note;
    logic [7:0]          w_rom_data;
    logic [3:0]          w_rom_pitch;
    logic [3:0]          w_rom_dur;

    // The ROM is addressed with the next index so its output matches
    // note_idx during the single LOAD cycle.
    buzzer_note_rom #(
        .TABLE (NOTE_TABLE)
    ) u_note_rom (
        .clk    (system_clock),
        .i_addr (w_note_idx_nxt),
        .o_data (w_rom_data)
    );

    assign w_rom_pitch   = w_rom_data[7:4];
    assign w_rom_dur     = w_rom_data[3:0];
    assign w_tick_strobe = (r_tick_cnt == c_TICK_MAX);

    // Tick timebase restarts whenever a note or gap begins.
    assign w_tick_restart = (w_state_nxt != r_state) &&
                            ((w_state_nxt == S_PLAY) || (w_state_nxt == S_GAP));

    // State, counters and all outputs are registered together.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_note_idx <= '0;
            r_period   <= '0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= (w_tick_restart || w_tick_strobe) ? '0 : r_tick_cnt + 1'b1;
            r_dur_cnt  <= w_dur_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_note_idx <= w_note_idx_nxt;
            r_period   <= w_period_nxt;
            r_tone_en  <= w_tone_en_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_note_idx_nxt = r_note_idx;
        w_period_nxt   = r_period;
        w_tone_en_nxt  = r_tone_en;
        w_dur_cnt_nxt  = r_dur_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_done_nxt     = 1'b0;
        w_end_of_note  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_period_nxt  = '0;
                w_tone_en_nxt = 1'b0;
                if (bus.start && !bus.stop) begin
                    w_state_nxt    = S_LOAD;
                    w_note_idx_nxt = '0;
                end
            end
            S_LOAD: begin
                w_state_nxt   = S_PLAY;
                w_period_nxt  = pitch_period(w_rom_pitch);
                w_tone_en_nxt = pitch_audible(w_rom_pitch);
                w_dur_cnt_nxt = (w_rom_dur == 4'd0) ? 4'd1 : w_rom_dur;
            end
            S_PLAY: begin
                if (w_tick_strobe) begin
                    if (r_dur_cnt <= 4'd1) begin
                        if (c_GAP != 4'd0) begin
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = c_GAP;
                            w_period_nxt  = '0;
                            w_tone_en_nxt = 1'b0;
                        end else begin
                            w_end_of_note = 1'b1;
                        end
                    end else begin
                        w_dur_cnt_nxt = r_dur_cnt - 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (w_tick_strobe) begin
                    if (r_gap_cnt <= 4'd1) begin
                        w_end_of_note = 1'b1;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Advance, wrap (loop_en only matters here) or finish the song.
        if (w_end_of_note) begin
            w_period_nxt  = '0;
            w_tone_en_nxt = 1'b0;
            if (r_note_idx < c_LAST_IDX) begin
                w_state_nxt    = S_LOAD;
                w_note_idx_nxt = r_note_idx + 4'd1;
            end else if (bus.loop_en) begin
                w_state_nxt    = S_LOAD;
                w_note_idx_nxt = '0;
            end else begin
                w_state_nxt    = S_IDLE;
                w_note_idx_nxt = '0;
                w_done_nxt     = 1'b1;
            end
        end

        // An abort overrides everything outside IDLE and never signals done.
        if (bus.stop && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_note_idx_nxt = '0;
            w_period_nxt   = '0;
            w_tone_en_nxt  = 1'b0;
            w_done_nxt     = 1'b0;
        end
    end

    assign bus.period   = r_period;
    assign bus.tone_en  = r_tone_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.note_idx = r_note_idx;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_melody_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_buzzer_melody_seq
// Description : Self-checking bench for buzzer_melody_seq with a short
//               three-note song; expected per-cycle outputs are queued as
//               stimulus is applied and compared on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_melody_seq;

    localparam int c_TICK = 9;
    localparam int c_GAPT = 1;
    localparam int c_LEN  = 3;

    localparam logic [17:0] c_EXP_PERIOD [16] = '{
        18'd0, 18'd190839, 18'd170067, 18'd151514, 18'd143265, 18'd127550,
        18'd113635, 18'd101213, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
        18'd0, 18'd0
    };

    typedef struct packed {
        logic [17:0] period;
        logic        tone_en;
        logic        busy;
        logic        done;
        logic [3:0]  note_idx;
    } exp_t;

    logic system_clock = 1'b0;
    logic system_reset = 1'b1;
    logic [7:0] song [3] = '{8'h12, 8'h01, 8'h73};

    exp_t sb [$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    buzzer_melody_seq_if bus ();

    buzzer_melody_seq #(
        .TICK_MAX   (c_TICK),
        .SONG_LEN   (c_LEN),
        .GAP_TICKS  (c_GAPT),
        .NOTE_TABLE ({104'h0, 8'h73, 8'h01, 8'h12})
    ) u_dut (
        .system_clock (system_clock),
        .system_reset (system_reset),
        .bus          (bus)
    );

    always #5 system_clock = ~system_clock;

    // Scoreboard: one queued expectation is consumed per falling edge.
    always @(negedge system_clock) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_compared++;
            if ({bus.period, bus.tone_en, bus.busy, bus.done, bus.note_idx} !== mon_e) begin
                n_mismatched++;
                if (n_mismatched <= 40)
                    $display("FAIL cycle_check t=%0t got period=%0d tone=%b busy=%b done=%b idx=%0d expected period=%0d tone=%b busy=%b done=%b idx=%0d",
                             $time, bus.period, bus.tone_en, bus.busy, bus.done, bus.note_idx,
                             mon_e.period, mon_e.tone_en, mon_e.busy, mon_e.done, mon_e.note_idx);
            end
        end
    end

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_cyc(input logic [17:0] p, input logic t, input logic b,
                            input logic d, input logic [3:0] idx, input int n);
        exp_t e;
        e.period   = p;
        e.tone_en  = t;
        e.busy     = b;
        e.done     = d;
        e.note_idx = idx;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    task automatic push_idle(input int n);
        push_cyc(18'd0, 1'b0, 1'b0, 1'b0, 4'd0, n);
    endtask

    task automatic push_done();
        push_cyc(18'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1);
    endtask

    function automatic int play_cycles(input int i);
        int d;
        d = int'(song[i][3:0]);
        if (d == 0) d = 1;
        return d * (c_TICK + 1);
    endfunction

    task automatic push_load(input int i);
        push_cyc(18'd0, 1'b0, 1'b1, 1'b0, 4'(i), 1);
    endtask

    task automatic push_play(input int i, input int n);
        logic [3:0] pc;
        pc = song[i][7:4];
        push_cyc(c_EXP_PERIOD[pc], (pc >= 4'd1 && pc <= 4'd7), 1'b1, 1'b0, 4'(i), n);
    endtask

    task automatic push_gap(input int i, input int n);
        push_cyc(18'd0, 1'b0, 1'b1, 1'b0, 4'(i), n);
    endtask

    task automatic push_note(input int i);
        push_load(i);
        push_play(i, play_cycles(i));
        push_gap(i, c_GAPT * (c_TICK + 1));
    endtask

    // Returns just after the rising edge following the last expected cycle.
    task automatic wait_drain();
        int guard;
        guard = 0;
        do begin
            @(posedge system_clock);
            guard++;
        end while (sb.size() != 0 && guard < 2000);
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain_timeout: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
        #2;
    endtask

    task automatic sync();
        @(posedge system_clock);
        #2;
    endtask

    task automatic test_reset();
        system_reset = 1'b1;
        repeat (3) @(posedge system_clock);
        #2;
        system_reset = 1'b0;
        @(negedge system_clock);
        n_compared++;
        if (bus.period !== 18'd0) begin
            n_mismatched++;
            $display("FAIL reset_period got %0d required 0", bus.period);
        end
        n_compared++;
        if (bus.tone_en !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_tone_en got %b required 0", bus.tone_en);
        end
        n_compared++;
        if (bus.busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_busy got %b required 0", bus.busy);
        end
        n_compared++;
        if (bus.done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_done got %b required 0", bus.done);
        end
        n_compared++;
        if (bus.note_idx !== 4'd0) begin
            n_mismatched++;
            $display("FAIL reset_note_idx got %0d required 0", bus.note_idx);
        end
    endtask

    task automatic test_full_song();
        sync();
        bus.start = 1'b1;
        push_idle(1);
        for (int i = 0; i < c_LEN; i++) push_note(i);
        push_done();
        push_idle(3);
        sync();
        bus.start = 1'b0;
        wait_drain();
    endtask

    task automatic test_loop();
        sync();
        bus.loop_en = 1'b1;
        bus.start   = 1'b1;
        push_idle(1);
        for (int i = 0; i < c_LEN; i++) push_note(i);
        push_load(0);
        push_play(0, play_cycles(0));
        sync();
        bus.start = 1'b0;
        wait_drain();
        bus.stop    = 1'b1;
        bus.loop_en = 1'b0;
        push_gap(0, 1);
        push_idle(3);
        sync();
        bus.stop = 1'b0;
        wait_drain();
    endtask

    task automatic test_stop_mid_play();
        sync();
        bus.start = 1'b1;
        push_idle(1);
        push_note(0);
        push_note(1);
        push_load(2);
        push_play(2, 12);
        sync();
        bus.start = 1'b0;
        wait_drain();
        bus.stop = 1'b1;
        push_play(2, 1);
        push_idle(5);
        sync();
        bus.stop = 1'b0;
        wait_drain();
    endtask

    task automatic test_start_stop_idle();
        sync();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        push_idle(4);
        sync();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        sync();
        bus.start = 1'b1;
        push_idle(1);
        push_load(0);
        push_play(0, 6);
        sync();
        bus.start = 1'b0;
        wait_drain();
        bus.start = 1'b1;
        push_play(0, play_cycles(0) - 6);
        push_gap(0, c_GAPT * (c_TICK + 1));
        push_note(1);
        push_note(2);
        push_done();
        push_idle(2);
        sync();
        bus.start = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid_gap();
        sync();
        bus.start = 1'b1;
        push_idle(1);
        push_load(0);
        push_play(0, play_cycles(0));
        push_gap(0, 4);
        sync();
        bus.start = 1'b0;
        wait_drain();
        system_reset = 1'b1;
        push_gap(0, 1);
        push_idle(3);
        sync();
        system_reset = 1'b0;
        wait_drain();
        test_full_song();
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        test_reset();
        test_full_song();
        test_loop();
        test_stop_mid_play();
        test_start_stop_idle();
        test_back_to_back();
        test_reset_mid_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/buzzer_melody_seq.md
BUZZER_MELODY_SEQ -- requirements
Module: buzzer_melody_seq

Interface
REQ-001 SHALL have parameter TICK_MAX, default 499_999; tick period minus 1 in clocks (10 ms at 50 MHz).
REQ-002 SHALL have parameter SONG_LEN, default 16; number of valid note-table entries, range 1..16.
REQ-003 SHALL have parameter GAP_TICKS, default 2; silent ticks inserted after every note, range 0..15.
REQ-004 SHALL have port system_clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port system_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin playback from entry 0.
REQ-007 SHALL have port stop  input  1  single-cycle request to abort playback.
REQ-008 SHALL have port loop_en  input  1  when high at song end, playback restarts at entry 0.
REQ-009 SHALL have port period  output  18  half-wave period for the tone generator (clocks); 0 when silent.
REQ-010 SHALL have port tone_en  output  1  high while an audible note plays.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on normal song completion.
REQ-013 SHALL have port note_idx  output  4  index of the entry currently loaded or playing.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, PLAY, GAP.
REQ-015 SHALL run a free-running tick counter 0..TICK_MAX; tick_strobe is high on the cycle the counter equals TICK_MAX; counter restarts at 0 on every entry to PLAY or GAP.
REQ-016 Note entry SHALL be 8 bits: pitch[7:4] (0 = rest, 1..7 = DO..XI, 8..15 treated as rest) and dur[3:0] in ticks (0 treated as 1).
REQ-017 IDLE: start=1 and stop=0 -> LOAD with note_idx=0; start is ignored in every other state.
REQ-018 LOAD: lasts exactly 1 cycle (table read latency); -> PLAY, registering period from pitch lookup and duration counter = dur.
REQ-019 PLAY: tone_en=1 iff pitch is 1..7; period = looked-up value, 0 for rest; duration counter decrements on tick_strobe; at count 1 with tick_strobe -> GAP (or end-of-note handling directly if GAP_TICKS=0).
REQ-020 GAP: tone_en=0, period=0; lasts GAP_TICKS ticks, then end-of-note handling.
REQ-021 End-of-note: note_idx < SONG_LEN-1 -> note_idx+1, LOAD; note_idx = SONG_LEN-1 and loop_en=1 -> note_idx=0, LOAD, no done; else -> IDLE, done=1 for one cycle.
REQ-022 stop=1 in LOAD/PLAY/GAP -> IDLE next cycle, tone_en=0, period=0, note_idx=0, done not asserted.
REQ-023 stop and start high together in IDLE: stop wins, stays IDLE.
REQ-024 Pitch lookup SHALL return DO=190839, RE=170067, MI=151514, FA=143265, SO=127550, LA=113635, XI=101213.
REQ-025 All outputs SHALL be registered; loop_en is sampled only at end-of-note of the last entry.

Reset
REQ-026 system_reset=1 SHALL force IDLE, note_idx=0, period=0, tone_en=0, busy=0, done=0, tick counter=0, on the next rising edge, from any state including mid-note.

Structure
REQ-027 Pitch constants, pitch codes and FSM state encoding SHALL live in shared package buzzer_pkg.
REQ-028 Note table SHALL be sub-module buzzer_note_rom (16x8, registered read, 1-cycle latency).

Verification (TICK_MAX=9, GAP_TICKS=1, SONG_LEN=3, table {0x12, 0x01, 0x73})
REQ-029 Reset then start pulse -> busy=1 next cycle; tone_en=1, period=190839 for 20 cycles; gap 10 cycles with tone_en=0.
REQ-030 Entry 1 (rest, dur 1) -> period=0, tone_en=0 for 10 cycles; entry 2 -> period=101213 for 30 cycles; then done pulse 1 cycle, busy=0.
REQ-031 loop_en=1 through song end -> note_idx 2->0, no done pulse, period returns to 190839.
REQ-032 stop mid-PLAY of entry 2 -> next cycle IDLE, tone_en=0, period=0, note_idx=0, no done.
REQ-033 start and stop same cycle in IDLE -> busy stays 0; start while busy -> no effect on note_idx.
REQ-034 system_reset asserted mid-GAP -> all outputs at reset values next cycle; fresh start replays from entry 0.
